// File: rtl/mem_req_arbiter_pkg.sv
// Shared types, field widths and width helpers for the memory-request arbiter.
package mem_req_arb_pkg;

    localparam int BAR_W  = 3;
    localparam int ADDR_W = 32;
    localparam int BE_W   = 4;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Index width for n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester, memory-request and completion signals of the arbiter, bundled.
interface mem_req_arb_if #(
    parameter int NUM_REQ           = 2,
    parameter int OUTSTANDING_READS = 5
);
    import mem_req_arb_pkg::*;

    localparam int CNT_W = clog2(OUTSTANDING_READS + 1);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [BAR_W*NUM_REQ-1:0]  req_bar_hit;
    logic [ADDR_W*NUM_REQ-1:0] req_pcie_address;
    logic [BE_W*NUM_REQ-1:0]   req_byte_enable;
    logic [NUM_REQ-1:0]        req_write_readn;
    logic [NUM_REQ-1:0]        req_phys_func;
    logic [DATA_W*NUM_REQ-1:0] req_write_data;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [BAR_W-1:0]          mem_req_bar_hit;
    logic [ADDR_W-1:0]         mem_req_pcie_address;
    logic [BE_W-1:0]           mem_req_byte_enable;
    logic                      mem_req_write_readn;
    logic                      mem_req_phys_func;
    logic [DATA_W-1:0]         mem_req_write_data;

    logic                      axi_cpld_valid;
    logic                      axi_cpld_ready;
    logic [DATA_W-1:0]         axi_cpld_data;
    logic [NUM_REQ-1:0]        cpld_valid;
    logic [NUM_REQ-1:0]        cpld_ready;
    logic [DATA_W-1:0]         cpld_data;

    logic [CNT_W-1:0]          outstanding_count;
    logic                      err_orphan_cpld;

    modport master (
        input  req_valid, req_bar_hit, req_pcie_address, req_byte_enable,
               req_write_readn, req_phys_func, req_write_data,
               mem_req_ready, axi_cpld_valid, axi_cpld_data, cpld_ready,
        output req_ready, mem_req_valid, mem_req_bar_hit, mem_req_pcie_address,
               mem_req_byte_enable, mem_req_write_readn, mem_req_phys_func,
               mem_req_write_data, axi_cpld_ready, cpld_valid, cpld_data,
               outstanding_count, err_orphan_cpld
    );

    modport slave (
        output req_valid, req_bar_hit, req_pcie_address, req_byte_enable,
               req_write_readn, req_phys_func, req_write_data,
               mem_req_ready, axi_cpld_valid, axi_cpld_data, cpld_ready,
        input  req_ready, mem_req_valid, mem_req_bar_hit, mem_req_pcie_address,
               mem_req_byte_enable, mem_req_write_readn, mem_req_phys_func,
               mem_req_write_data, axi_cpld_ready, cpld_valid, cpld_data,
               outstanding_count, err_orphan_cpld
    );

endinterface

// File: rtl/mem_req_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs for reads in flight; head is visible without a pop.
module mem_req_tag_fifo
    import mem_req_arb_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = id_width(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr];

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory-request port among NUM_REQ requesters,
// with in-order completion steering back to the requester that issued each read.
module mem_req_arbiter
    import mem_req_arb_pkg::*;
#(
    parameter int NUM_REQ           = 2,
    parameter int OUTSTANDING_READS = 5
) (
    input  logic          m_axi_aclk,
    input  logic          m_axi_areset,
    mem_req_arb_if.master bus
);
    // state | meaning
    // IDLE  | looking for an eligible requester; grant is combinational
    // HOLD  | registered request presented downstream until mem_req_ready

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = clog2(OUTSTANDING_READS + 1);

    arb_state_e         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_q;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               grant_en;
    logic [NUM_REQ-1:0] elig;

    logic               mem_valid_q;
    logic [BAR_W-1:0]   bar_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BE_W-1:0]    be_q;
    logic               wr_q;
    logic               pf_q;
    logic [DATA_W-1:0]  data_q;

    logic [BAR_W-1:0]   sel_bar;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BE_W-1:0]    sel_be;
    logic               sel_wr;
    logic               sel_pf;
    logic [DATA_W-1:0]  sel_data;

    logic               fifo_push;
    logic               fifo_pop;
    logic [ID_W-1:0]    fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [NUM_REQ-1:0] cpl_valid;
    logic               cpl_ready;
    logic               orphan_q;

    // A full tag FIFO stalls reads only; the current count is used, so a pop
    // in the same cycle does not free a slot until the next one.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i] && (bus.req_write_readn[i] || !fifo_full);
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && elig[i] && (i >= int'(rr_ptr))) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && elig[i] && (i < int'(rr_ptr))) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
    end

    assign grant_en = (state == IDLE) && gnt_any && !m_axi_areset;

    always_comb begin
        bus.req_ready = '0;
        sel_bar       = '0;
        sel_addr      = '0;
        sel_be        = '0;
        sel_wr        = 1'b0;
        sel_pf        = 1'b0;
        sel_data      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                bus.req_ready[i] = grant_en;
                sel_bar          = bus.req_bar_hit[i*BAR_W +: BAR_W];
                sel_addr         = bus.req_pcie_address[i*ADDR_W +: ADDR_W];
                sel_be           = bus.req_byte_enable[i*BE_W +: BE_W];
                sel_wr           = bus.req_write_readn[i];
                sel_pf           = bus.req_phys_func[i];
                sel_data         = bus.req_write_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state       <= IDLE;
            mem_valid_q <= 1'b0;
            rr_ptr      <= '0;
            gnt_q       <= '0;
            bar_q       <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wr_q        <= 1'b0;
            pf_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        bar_q       <= sel_bar;
                        addr_q      <= sel_addr;
                        be_q        <= sel_be;
                        wr_q        <= sel_wr;
                        pf_q        <= sel_pf;
                        data_q      <= sel_data;
                        gnt_q       <= gnt_idx;
                        rr_ptr      <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        mem_valid_q <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.mem_req_ready) begin
                        mem_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_push = (state == HOLD) && mem_valid_q && bus.mem_req_ready && !wr_q;
    assign fifo_pop  = bus.axi_cpld_valid && cpl_ready && !fifo_empty;

    mem_req_tag_fifo #(
        .W     (ID_W),
        .DEPTH (OUTSTANDING_READS),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk   (m_axi_aclk),
        .rst   (m_axi_areset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (gnt_q),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // With no tag to steer by, completions are drained rather than left stuck.
    always_comb begin
        cpl_valid = '0;
        cpl_ready = 1'b1;
        if (!fifo_empty) begin
            cpl_ready = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fifo_head == ID_W'(i)) begin
                    cpl_valid[i] = bus.axi_cpld_valid;
                    cpl_ready    = bus.cpld_ready[i];
                end
            end
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            orphan_q <= 1'b0;
        end else if (bus.axi_cpld_valid && fifo_empty) begin
            orphan_q <= 1'b1;
        end
    end

    assign bus.mem_req_valid        = mem_valid_q;
    assign bus.mem_req_bar_hit      = bar_q;
    assign bus.mem_req_pcie_address = addr_q;
    assign bus.mem_req_byte_enable  = be_q;
    assign bus.mem_req_write_readn  = wr_q;
    assign bus.mem_req_phys_func    = pf_q;
    assign bus.mem_req_write_data   = data_q;
    assign bus.cpld_valid           = cpl_valid;
    assign bus.axi_cpld_ready       = cpl_ready;
    assign bus.cpld_data            = bus.axi_cpld_data;
    assign bus.outstanding_count    = fifo_count;
    assign bus.err_orphan_cpld      = orphan_q;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one memory-request TLP port, the mem_req_* interface of the PCIe-to-AXI-Lite master controller, among NUM_REQ requesters. Typical requesters: the PCIe RX request decoder and a local debug/config master.
- Round-robin arbitration with a registered output stage.
- Records the requester ID of every accepted read in an in-order tag FIFO and steers each returning completion (axi_cpld_*) back to that requester.
- The downstream controller runs with relaxed ordering disabled, so completions return in issue order.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- OUTSTANDING_READS, 5, maximum reads in flight; equals the tag FIFO depth.
- ID_W, derived as clog2(NUM_REQ) with a minimum of 1, width of the requester ID.

Ports:
- m_axi_aclk  in  1  clock.
- m_axi_areset  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_bar_hit  in  3*NUM_REQ  packed; requester i occupies [3i+2:3i].
- req_pcie_address  in  32*NUM_REQ  packed.
- req_byte_enable  in  4*NUM_REQ  packed.
- req_write_readn  in  NUM_REQ  1 = write, 0 = read.
- req_phys_func  in  NUM_REQ  physical function.
- req_write_data  in  32*NUM_REQ  packed.
- mem_req_valid  out  1  to controller.
- mem_req_ready  in  1  from controller.
- mem_req_bar_hit  out  3.
- mem_req_pcie_address  out  32.
- mem_req_byte_enable  out  4.
- mem_req_write_readn  out  1.
- mem_req_phys_func  out  1.
- mem_req_write_data  out  32.
- axi_cpld_valid  in  1  completion from controller.
- axi_cpld_ready  out  1.
- axi_cpld_data  in  32.
- cpld_valid  out  NUM_REQ  per-requester completion valid.
- cpld_ready  in  NUM_REQ.
- cpld_data  out  32  broadcast copy of axi_cpld_data.
- outstanding_count  out  clog2(OUTSTANDING_READS+1)  reads in flight.
- err_orphan_cpld  out  1  sticky: a completion arrived while the tag FIFO was empty.

Behaviour:
- Reset (synchronous, while m_axi_areset=1):
  - state=IDLE; mem_req_valid=0; req_ready=0; cpld_valid=0.
  - RR pointer=0; FIFO pointers and count=0; outstanding_count=0; err_orphan_cpld=0.
  - mem_req_* payload registers cleared to 0.
- Eligibility: requester i is eligible when req_valid[i]=1 and it is either a write, or a read with count < OUTSTANDING_READS.
  - A full FIFO blocks reads only; writes still proceed.
- State IDLE:
  - If any requester is eligible, grant the first one at or after the RR pointer, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle only.
  - Payload is captured into the output registers; the RR pointer becomes (g+1) mod NUM_REQ; next state is HOLD.
  - A registered copy of g is held for the FIFO push.
- State HOLD:
  - mem_req_valid=1 and the payload is stable; all req_ready=0.
  - On mem_req_valid & mem_req_ready: if it is a read, push g into the FIFO; next state is IDLE.
  - Sustained throughput is one request per 2 cycles minimum; a request is accepted 1 cycle after req_valid at the earliest.
- The eligibility check uses the current count. A pop in the same cycle is not credited, which is conservative.
- Completion routing, combinational:
  - FIFO non-empty: cpld_valid[head]=axi_cpld_valid, all other cpld_valid=0, axi_cpld_ready=cpld_ready[head].
  - Pop on axi_cpld_valid & axi_cpld_ready.
- FIFO empty while axi_cpld_valid=1:
  - axi_cpld_ready=1 (drain) and all cpld_valid=0.
  - err_orphan_cpld is set and stays set until reset.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap at OUTSTANDING_READS, which need not be a power of 2.
- outstanding_count equals the FIFO count, registered.
- Reset mid-operation: an in-flight HOLD request and all tags are discarded. The system must reset the downstream controller in the same cycle; any later stray completion is flagged orphan.
- Assertion: the FIFO never pushes when full, which is guaranteed by the eligibility rule.

Decomposition:
- Package mem_req_arb_pkg holds:
  - state encoding (IDLE=0, HOLD=1);
  - the clog2 function and ID_W derivation;
  - the field widths BAR_W=3, ADDR_W=32, BE_W=4, DATA_W=32.
- Sub-module mem_req_tag_fifo: a synchronous FIFO of ID_W-bit entries, depth OUTSTANDING_READS.
  - Ports: push/pop/din/dout/count/full/empty.
  - Register-based; first-word-fall-through head.

Test Plan:
1. Single write: req0 write, addr 0x0000_0010, data 0xDEAD_BEEF, be 0xF. Expect req_ready[0] one cycle, then mem_req_valid with identical payload held until mem_req_ready. outstanding_count stays 0.
2. Round-robin: req0 and req1 hold valid writes continuously with mem_req_ready=1. Grant order is 0,1,0,1; each request is issued every 2 cycles.
3. Read routing: req1 read, then req0 read, then two completions 0x1111_1111 and 0x2222_2222. cpld_valid[1] fires with 0x1111_1111, then cpld_valid[0] with 0x2222_2222. Count goes 0→2→0.
4. Full blocking: 5 reads issued with no completions, count=5. Then a req0 read and a req1 write are both valid. Only the write is granted. After one completion pops, the read is granted.
5. Completion backpressure and simultaneous events: head requester holds cpld_ready=0 for 3 cycles, so axi_cpld_ready=0 and data is held. Pop and push in the same cycle leave the count unchanged.
6. Orphan and reset: a completion with an empty FIFO gets axi_cpld_ready=1 and err_orphan_cpld=1. Reset during HOLD with 2 outstanding gives mem_req_valid=0, count=0, err=0 next cycle.
